rtc_time_counter: RTL
=====================

# rtc_time_counter

Real-time hour/minute/second counter for the digital clock datapath. It divides the system clock down to a 1 Hz tick and keeps time in packed BCD on a 24-hour cycle (00:00:00 to 23:59:59). Its registered time digits feed the display decode stage. Its one-cycle rollover strobes feed the downstream gate-level combining logic that builds alarm, chime and clear terms.

## Interface
- TICK_DIV, default 100000000: system-clock cycles per second tick. Legal range is 2 or greater. Benches use 4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  count enable. When 0, the prescaler and the time registers hold.
- load  in  1  one-cycle set request. Captures set_hh, set_mm and set_ss.
- set_hh  in  8  BCD hours to load: tens digit in [7:4], units digit in [3:0].
- set_mm  in  8  BCD minutes to load.
- set_ss  in  8  BCD seconds to load.
- hh  out  8  current hours, BCD.
- mm  out  8  current minutes, BCD.
- ss  out  8  current seconds, BCD.
- sec_pulse  out  1  one-cycle strobe on every second increment.
- min_wrap  out  1  one-cycle strobe when ss rolls 59 to 00.
- hour_wrap  out  1  one-cycle strobe when mm:ss rolls 59:59 to 00:00.
- day_wrap  out  1  one-cycle strobe when 23:59:59 rolls to 00:00:00.
- load_err  out  1  sticky flag: the last load was rejected.

## Operation
- Reset (asynchronous, takes effect immediately):
  - Prescaler = 0.
  - hh = mm = ss = 8'h00.
  - sec_pulse, min_wrap, hour_wrap, day_wrap = 0.
  - load_err = 0.
- Prescaler:
  - Width is ceil(log2(TICK_DIV)).
  - Counts 0 to TICK_DIV-1 while run=1, then wraps to 0.
  - The internal tick is asserted when the prescaler equals TICK_DIV-1 and run=1.
- Second increment on tick:
  - ss units digit +1. At 9 it becomes 0 and the tens digit +1.
  - At ss = 59, ss becomes 00 and a minute carry is generated.
- Minute carry: mm increments by the same rule. At mm = 59, mm becomes 00 and an hour carry is generated.
- Hour carry: hh increments by BCD rules.
  - 09 goes to 10 and 19 goes to 20.
  - 23 goes to 00 and asserts day_wrap.
- Strobe nesting: every day_wrap also asserts hour_wrap, min_wrap and sec_pulse in the same cycle.
- Digit range: digits never leave the legal BCD ranges: hh at most 23, mm and ss at most 59.
- Load validation. A load is valid only when all of these hold:
  - every nibble is 9 or less;
  - set_hh is 23 or less;
  - set_mm and set_ss are 59 or less.
- Valid load:
  - hh, mm and ss take the set values on the next edge.
  - The prescaler clears to 0.
  - load_err clears.
  - No strobes are asserted in that cycle.
- Invalid load: time and prescaler are unchanged, and load_err is set to 1.
- Load behaviour is identical whether run is 0 or 1.
- Simultaneous load and tick: load wins. The tick is discarded and no strobe is asserted.
- run deasserted mid-second: the prescaler value is kept. Counting resumes from that value when run returns to 1.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Tick latency:
  - The edge that moves the prescaler off TICK_DIV-1 also updates ss and asserts sec_pulse.
  - The strobes are therefore coincident with the new time value and last exactly one cycle.
- Second period: with run held at 1, consecutive sec_pulse assertions are exactly TICK_DIV cycles apart.
- Load latency: the new time is visible one edge after load=1 is sampled.
  - The first following sec_pulse comes exactly TICK_DIV cycles after that edge.
- load_err: updates on the same edge as the load it reports. It holds until the next valid load or reset.
- Reset mid-second or mid-load: everything returns to the reset values. No strobe is emitted as reset releases.
- load held high for several cycles: each cycle is treated as a separate load. While load is held, the prescaler stays at 0.

## Test plan
- Basic counting:
  - Stimulus: TICK_DIV=4, release reset, run=1, run 12 cycles.
  - Required: ss steps 00, 01, 02, 03, with one sec_pulse every 4 cycles and no wrap strobes.
- Minute roll:
  - Stimulus: load 00:00:58, then run=1.
  - Required: after 2 ticks, ss=00 and mm=01, with min_wrap and sec_pulse together for one cycle.
- Day roll:
  - Stimulus: load 23:59:59, then one tick.
  - Required: 00:00:00, with day_wrap, hour_wrap, min_wrap and sec_pulse all high for one cycle.
- Invalid loads:
  - Stimulus: load 24:00:00, then 12:60:00, then 12:0A:00.
  - Required: time unchanged and load_err=1 each time.
  - Follow-up: a later load of 12:34:56 clears load_err and shows 12:34:56.
- Load/tick collision and hold:
  - Stimulus: assert load on the cycle where the prescaler is 3. Separately, drop run for 10 cycles mid-second.
  - Required: for the collision, the loaded value appears with no strobe and the next sec_pulse comes 4 cycles later.
  - Required: while run=0 the time is frozen; the remaining fraction of the second resumes when run returns to 1.
- Asynchronous reset:
  - Stimulus: pulse rst between clock edges while counting at 07:15:30.
  - Required: outputs go to 00:00:00 with all strobes low immediately, not waiting for the next clock edge.

Source files
------------

// File: rtl/rtc_time_counter.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler, validated time load
// and one-cycle nested rollover strobes. All outputs come straight from flops.
module rtc_time_counter #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       min_wrap,
  output logic       hour_wrap,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Packed BCD with legal nibbles orders the same as its numeric value.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  // Returns {carry, next value}; wraps to 00 once max_v is reached.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [3:0] tens_inc;
    logic [3:0] units_inc;
    tens_inc  = v[7:4] + 4'd1;
    units_inc = v[3:0] + 4'd1;
    if (v == max_v) begin
      return {1'b1, 8'h00};
    end else if (v[3:0] == 4'd9) begin
      return {1'b0, tens_inc, 4'd0};
    end else begin
      return {1'b0, v[7:4], units_inc};
    end
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic          sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
  logic          err_q, err_d;
  logic          tick_s, load_ok_s;
  logic [8:0]    ss_inc_s, mm_inc_s, hh_inc_s;

  assign tick_s    = run && (presc_q == PRESC_LAST);
  assign load_ok_s = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
  assign ss_inc_s  = bcd_inc(ss_q, 8'h59);
  assign mm_inc_s  = bcd_inc(mm_q, 8'h59);
  assign hh_inc_s  = bcd_inc(hh_q, 8'h23);

  // Next-state: load has priority and swallows any coincident tick.
  always_comb begin
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    err_d   = err_q;
    sec_d   = 1'b0;
    min_d   = 1'b0;
    hour_d  = 1'b0;
    day_d   = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        hh_d    = set_hh;
        mm_d    = set_mm;
        ss_d    = set_ss;
        presc_d = '0;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (run) begin
      if (tick_s) begin
        presc_d = '0;
        sec_d   = 1'b1;
        ss_d    = ss_inc_s[7:0];
        min_d   = ss_inc_s[8];
        if (ss_inc_s[8]) begin
          mm_d   = mm_inc_s[7:0];
          hour_d = mm_inc_s[8];
          if (mm_inc_s[8]) begin
            hh_d  = hh_inc_s[7:0];
            day_d = hh_inc_s[8];
          end else begin
            hh_d  = hh_q;
          end
        end else begin
          mm_d = mm_q;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      sec_q   <= 1'b0;
      min_q   <= 1'b0;
      hour_q  <= 1'b0;
      day_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      err_q   <= err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_pulse = sec_q;
  assign min_wrap  = min_q;
  assign hour_wrap = hour_q;
  assign day_wrap  = day_q;
  assign load_err  = err_q;

endmodule
